// File: rtl/move_sequencer.sv
// ============================================================================
// move_sequencer
// ----------------------------------------------------------------------------
// Front end for the tic-tac-toe game core. It turns the bouncy confirm button
// and the row/col switches into one clean update strobe per move. It tracks
// whose turn it is, reads back err/game_over from the core to decide between
// turn handoff, retry and end of game, and issues a one-cycle core reset when
// a new game is started.
//
// Optional feature macro: MOVE_TIMEOUT_EN
//   defined   : an idle counter forfeits the current player's turn after
//               TIMEOUT_CYCLES idle cycles in IDLE (one-cycle timeout pulse).
//   undefined : no counter is built and timeout is tied to 0.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles the synchronised button must differ from the
//                     debounced level before it is accepted (>= 2)
//   SETTLE_CYCLES   : cycles waited after update before err/game_over are
//                     sampled (>= 1)
//   TIMEOUT_CYCLES  : idle cycles before a turn is forfeited (>= 2)
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   asynchronous active-high reset
//   btn_raw    in   confirm button, asynchronous and bouncy
//   row_sw     in   [1:0] selected row
//   col_sw     in   [1:0] selected column
//   new_game   in   level, starts a new game on its 0->1 edge
//   err        in   core: last move illegal
//   game_over  in   core: game finished
//   player     out  current player presented to the core
//   update     out  one-cycle move strobe to the core
//   row        out  [1:0] latched row of the move
//   col        out  [1:0] latched column of the move
//   busy       out  high while a move is in flight (ISSUE/SETTLE/CHECK)
//   retry      out  one-cycle pulse, move rejected, same player retries
//   game_rst   out  one-cycle reset pulse to the core
//   move_count out  [3:0] accepted moves this game, saturates at 9
//   timeout    out  one-cycle pulse, turn forfeited
// ============================================================================
module move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [1:0] row_sw,
    input  logic [1:0] col_sw,
    input  logic       new_game,
    input  logic       err,
    input  logic       game_over,
    output logic       player,
    output logic       update,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       busy,
    output logic       retry,
    output logic       game_rst,
    output logic [3:0] move_count,
    output logic       timeout
);

    localparam int SYNC_STAGES = 2;
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int ST_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0] MAX_MOVES = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic [DB_W-1:0]        db_cnt_reg;
    logic                   btn_db_reg;
    logic                   press_reg;
    logic                   btn_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = btn_raw;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign btn_sync = sync_reg[SYNC_STAGES-1];

    // The counter only runs while the synchronised level disagrees with the
    // debounced one; any sample that agrees restarts the stability window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= '0;
            db_cnt_reg <= '0;
            btn_db_reg <= 1'b0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            press_reg <= 1'b0;
            if (btn_sync == btn_db_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                btn_db_reg <= btn_sync;
                db_cnt_reg <= '0;
                // A press is the 0->1 transition of the debounced level.
                press_reg  <= btn_sync;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // new_game edge detector: a held level does not re-trigger.
    // ------------------------------------------------------------------------
    logic new_game_d_reg;
    logic ng_edge;

    assign ng_edge = new_game & ~new_game_d_reg;

    // ------------------------------------------------------------------------
    // Move sequencing FSM, all outputs registered
    // ------------------------------------------------------------------------
    state_t          state_reg;
    logic [ST_W-1:0] settle_cnt_reg;
    logic            player_reg;
    logic            update_reg;
    logic [1:0]      row_reg;
    logic [1:0]      col_reg;
    logic            busy_reg;
    logic            retry_reg;
    logic            game_rst_reg;
    logic [3:0]      move_count_reg;

`ifdef MOVE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt_reg;
    logic            timeout_reg;
`else
    // Kept so both builds share one parameter list; nothing depends on it here.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            settle_cnt_reg <= '0;
            player_reg     <= 1'b0;
            update_reg     <= 1'b0;
            row_reg        <= 2'd0;
            col_reg        <= 2'd0;
            busy_reg       <= 1'b0;
            retry_reg      <= 1'b0;
            game_rst_reg   <= 1'b0;
            move_count_reg <= 4'd0;
            new_game_d_reg <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            idle_cnt_reg   <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            update_reg     <= 1'b0;
            retry_reg      <= 1'b0;
            game_rst_reg   <= 1'b0;
            new_game_d_reg <= new_game;
`ifdef MOVE_TIMEOUT_EN
            timeout_reg    <= 1'b0;
`endif
            if (ng_edge) begin
                // New game overrides everything, including a move in flight.
                game_rst_reg   <= 1'b1;
                player_reg     <= 1'b0;
                move_count_reg <= 4'd0;
                busy_reg       <= 1'b0;
                settle_cnt_reg <= '0;
                state_reg      <= S_IDLE;
`ifdef MOVE_TIMEOUT_EN
                idle_cnt_reg   <= '0;
`endif
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (press_reg) begin
                            row_reg    <= row_sw;
                            col_reg    <= col_sw;
                            update_reg <= 1'b1;
                            busy_reg   <= 1'b1;
                            state_reg  <= S_ISSUE;
`ifdef MOVE_TIMEOUT_EN
                            idle_cnt_reg <= '0;
                        end else if (idle_cnt_reg == TO_LAST) begin
                            // Forfeit: hand the turn over without a move.
                            timeout_reg  <= 1'b1;
                            player_reg   <= ~player_reg;
                            idle_cnt_reg <= '0;
                        end else begin
                            idle_cnt_reg <= idle_cnt_reg + 1'b1;
`endif
                        end
                    end
                    S_ISSUE: begin
                        settle_cnt_reg <= '0;
                        state_reg      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt_reg == ST_LAST) begin
                            state_reg <= S_CHECK;
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        busy_reg <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
                        idle_cnt_reg <= '0;
`endif
                        // err outranks game_over: an illegal move never ends the game.
                        if (err) begin
                            retry_reg <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            if (move_count_reg != MAX_MOVES) begin
                                move_count_reg <= move_count_reg + 1'b1;
                            end
                            if (game_over) begin
                                state_reg <= S_OVER;
                            end else begin
                                player_reg <= ~player_reg;
                                state_reg  <= S_IDLE;
                            end
                        end
                    end
                    S_OVER: begin
                        // Presses are ignored; only new_game leaves this state.
                        state_reg <= S_OVER;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign player     = player_reg;
    assign update     = update_reg;
    assign row        = row_reg;
    assign col        = col_reg;
    assign busy       = busy_reg;
    assign retry      = retry_reg;
    assign game_rst   = game_rst_reg;
    assign move_count = move_count_reg;

`ifdef MOVE_TIMEOUT_EN
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_move_sequencer.sv
// ============================================================================
// tb_move_sequencer
// Directed bench for move_sequencer: one task per scenario, inline checks,
// inputs driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_move_sequencer;

    localparam int DEB = 16;
    localparam int SET = 2;
    localparam int TO  = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [1:0] row_sw;
    logic [1:0] col_sw;
    logic       new_game;
    logic       err;
    logic       game_over;
    logic       player;
    logic       update;
    logic [1:0] row;
    logic [1:0] col;
    logic       busy;
    logic       retry;
    logic       game_rst;
    logic [3:0] move_count;
    logic       timeout;

    int vecs = 0;
    int errs = 0;

    move_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SET),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .row_sw    (row_sw),
        .col_sw    (col_sw),
        .new_game  (new_game),
        .err       (err),
        .game_over (game_over),
        .player    (player),
        .update    (update),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .retry     (retry),
        .game_rst  (game_rst),
        .move_count(move_count),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_new_game;
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        step(1);
    endtask

    // Hold the button until update appears (bounded), then release.
    // Returns on the falling edge of the ISSUE cycle.
    task automatic press_until_update(output bit seen);
        seen = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(1);
            if (update === 1'b1) seen = 1'b1;
        end
        btn_raw = 1'b0;
        if (seen)
            $display("move: row=%0d col=%0d player=%0d count=%0d", row, col, player, move_count);
        else
            $display("move: no update within 40 cycles");
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1; btn_raw = 1'b0; row_sw = 2'd0; col_sw = 2'd0;
        new_game = 1'b0; err = 1'b0; game_over = 1'b0;
        step(2);
        vecs++;
        if ({player, update, row, col, busy, retry, game_rst, move_count, timeout} !== 14'd0) begin
            errs++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {player, update, row, col, busy, retry, game_rst, move_count, timeout});
        end
        rst = 1'b0;
        step(2);
        // Mid-move asynchronous reset
        do_new_game;
        row_sw = 2'd3; col_sw = 2'd3;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL rst_pre_update: got %0d expected 1", seen); end
        step(1);
        #2 rst = 1'b1;
        #1;
        vecs++;
        if ({player, update, row, col, busy, retry, game_rst, move_count, timeout} !== 14'd0) begin
            errs++;
            $display("FAIL rst_midmove_outputs: got %b expected 0",
                     {player, update, row, col, busy, retry, game_rst, move_count, timeout});
        end
        @(negedge clk);
        rst = 1'b0;
        begin
            int n = 0;
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (update === 1'b1) n++;
            end
            vecs++; if (n !== 0) begin errs++; $display("FAIL rst_no_partial_update: got %0d expected 0", n); end
        end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy_after: got %0d expected 0", busy); end
        // FSM must be back in IDLE: a fresh press is accepted
        row_sw = 2'd0; col_sw = 2'd1;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL rst_idle_press: got %0d expected 1", seen); end
        step(4 + DEB);
    endtask

    task automatic test_debounce;
        int n = 0;
        do_new_game;
        err = 1'b0; game_over = 1'b0; row_sw = 2'd0; col_sw = 2'd0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 3) % 2 == 0);
            step(1);
            if (update === 1'b1) n++;
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (update === 1'b1) n++;
        end
        btn_raw = 1'b0;
        for (int i = 0; i < DEB + 4; i++) begin
            step(1);
            if (update === 1'b1) n++;
        end
        $display("bounce: %0d update pulses", n);
        vecs++; if (n !== 1) begin errs++; $display("FAIL debounce_pulses: got %0d expected 1", n); end
        vecs++; if (move_count !== 4'd1) begin errs++; $display("FAIL debounce_count: got %0d expected 1", move_count); end
    endtask

    task automatic test_basic_move;
        bit seen;
        do_new_game;
        err = 1'b0; game_over = 1'b0; row_sw = 2'd1; col_sw = 2'd2;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL basic_update_seen: got %0d expected 1", seen); end
        vecs++; if ({row, col} !== 4'b0110) begin errs++; $display("FAIL basic_rowcol: got row=%0d col=%0d expected row=1 col=2", row, col); end
        vecs++; if (player !== 1'b0) begin errs++; $display("FAIL basic_player_issue: got %0d expected 0", player); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_issue: got %0d expected 1", busy); end
        row_sw = 2'd3; col_sw = 2'd0;
        step(1);
        vecs++; if (update !== 1'b0) begin errs++; $display("FAIL basic_update_width: got %0d expected 0", update); end
        vecs++; if ({row, col} !== 4'b0110) begin errs++; $display("FAIL basic_rowcol_hold: got row=%0d col=%0d expected row=1 col=2", row, col); end
        step(2);
        vecs++; if ({busy, player} !== 2'b10) begin errs++; $display("FAIL basic_check_state: got busy=%0d player=%0d expected busy=1 player=0", busy, player); end
        step(1);
        vecs++; if (player !== 1'b1) begin errs++; $display("FAIL basic_player_after: got %0d expected 1", player); end
        vecs++; if (move_count !== 4'd1) begin errs++; $display("FAIL basic_count_after: got %0d expected 1", move_count); end
        vecs++; if ({busy, retry} !== 2'b00) begin errs++; $display("FAIL basic_busy_retry_after: got %b expected 00", {busy, retry}); end
        step(DEB);
    endtask

    task automatic test_retry;
        bit seen;
        do_new_game;
        err = 1'b1; game_over = 1'b1; row_sw = 2'd2; col_sw = 2'd0;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL retry_update_seen: got %0d expected 1", seen); end
        step(4);
        vecs++; if (retry !== 1'b1) begin errs++; $display("FAIL retry_pulse: got %0d expected 1", retry); end
        vecs++; if ({player, move_count} !== 5'd0) begin errs++; $display("FAIL retry_unchanged: got player=%0d count=%0d expected 0 0", player, move_count); end
        step(1);
        vecs++; if (retry !== 1'b0) begin errs++; $display("FAIL retry_width: got %0d expected 0", retry); end
        err = 1'b0; game_over = 1'b0;
        step(DEB);
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL retry_second_update: got %0d expected 1", seen); end
        vecs++; if (player !== 1'b0) begin errs++; $display("FAIL retry_same_player: got %0d expected 0", player); end
        step(4);
        vecs++; if ({player, move_count} !== 5'b1_0001) begin errs++; $display("FAIL retry_second_result: got player=%0d count=%0d expected 1 1", player, move_count); end
        step(DEB);
    endtask

    task automatic test_game_over;
        bit seen;
        int n = 0;
        do_new_game;
        err = 1'b0; game_over = 1'b1; row_sw = 2'd1; col_sw = 2'd1;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL over_update_seen: got %0d expected 1", seen); end
        step(4);
        vecs++; if ({player, move_count} !== 5'b0_0001) begin errs++; $display("FAIL over_result: got player=%0d count=%0d expected 0 1", player, move_count); end
        game_over = 1'b0;
        step(DEB);
        for (int p = 0; p < 3; p++) begin
            btn_raw = 1'b1;
            for (int i = 0; i < DEB + 6; i++) begin step(1); if (update === 1'b1) n++; end
            btn_raw = 1'b0;
            for (int i = 0; i < DEB + 6; i++) begin step(1); if (update === 1'b1) n++; end
        end
        vecs++; if (n !== 0) begin errs++; $display("FAIL over_presses_ignored: got %0d expected 0", n); end
        vecs++; if (move_count !== 4'd1) begin errs++; $display("FAIL over_count_hold: got %0d expected 1", move_count); end
        new_game = 1'b1;
        step(1);
        vecs++; if (game_rst !== 1'b1) begin errs++; $display("FAIL over_game_rst: got %0d expected 1", game_rst); end
        vecs++; if ({player, move_count} !== 5'd0) begin errs++; $display("FAIL over_cleared: got player=%0d count=%0d expected 0 0", player, move_count); end
        n = 0;
        for (int i = 0; i < 4; i++) begin step(1); if (game_rst === 1'b1) n++; end
        vecs++; if (n !== 0) begin errs++; $display("FAIL over_held_new_game: got %0d extra pulses expected 0", n); end
        new_game = 1'b0;
        step(1);
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL over_new_game_play: got %0d expected 1", seen); end
        step(4 + DEB);
    endtask

    task automatic test_new_game_abort;
        bit seen;
        do_new_game;
        err = 1'b0; game_over = 1'b0; row_sw = 2'd2; col_sw = 2'd2;
        press_until_update(seen);
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL abort_update_seen: got %0d expected 1", seen); end
        new_game = 1'b1;
        step(1);
        new_game = 1'b0;
        vecs++; if ({game_rst, busy, update} !== 3'b100) begin errs++; $display("FAIL abort_pulse: got %b expected 100", {game_rst, busy, update}); end
        step(6);
        vecs++; if ({player, move_count, retry, busy} !== 7'd0) begin errs++; $display("FAIL abort_no_commit: got player=%0d count=%0d retry=%0d busy=%0d expected 0 0 0 0", player, move_count, retry, busy); end
        step(DEB);
    endtask

    task automatic test_saturation;
        bit seen;
        logic [3:0] exp_count;
        do_new_game;
        err = 1'b0; game_over = 1'b0;
        for (int k = 0; k < 10; k++) begin
            row_sw = 2'(k % 3); col_sw = 2'(k / 3);
            press_until_update(seen);
            vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL sat_update_%0d: got %0d expected 1", k, seen); end
            vecs++; if (player !== 1'(k % 2)) begin errs++; $display("FAIL sat_player_%0d: got %0d expected %0d", k, player, k % 2); end
            step(4);
            exp_count = (k + 1 > 9) ? 4'd9 : 4'(k + 1);
            vecs++; if (move_count !== exp_count) begin errs++; $display("FAIL sat_count_%0d: got %0d expected %0d", k, move_count, exp_count); end
            step(DEB);
        end
    endtask

    task automatic test_timeout;
        int n = 0;
        int first = -1;
        do_new_game;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (timeout === 1'b1) begin
                n++;
                if (first < 0) first = i;
            end
        end
`ifdef MOVE_TIMEOUT_EN
        vecs++; if (n !== 1) begin errs++; $display("FAIL timeout_pulses: got %0d expected 1", n); end
        vecs++; if (first < 44 || first > 52) begin errs++; $display("FAIL timeout_latency: got %0d expected 44..52", first); end
        vecs++; if ({player, move_count} !== 5'b1_0000) begin errs++; $display("FAIL timeout_effect: got player=%0d count=%0d expected 1 0", player, move_count); end
`else
        vecs++; if (n !== 0) begin errs++; $display("FAIL timeout_disabled: got %0d pulses expected 0", n); end
        vecs++; if (player !== 1'b0) begin errs++; $display("FAIL timeout_disabled_player: got %0d expected 0", player); end
`endif
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_basic_move;
        test_retry;
        test_game_over;
        test_new_game_abort;
        test_saturation;
        test_timeout;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
